// File: rtl/serial_pkg.sv
// serial_pkg: shared constants and state encoding for the DL11-style serial port.
package serial_pkg;

    // Byte offsets of the four word registers from BASE_ADDR.
    localparam logic [2:0] RCSR_OFS = 3'o0;
    localparam logic [2:0] RBUF_OFS = 3'o2;
    localparam logic [2:0] XCSR_OFS = 3'o4;
    localparam logic [2:0] XBUF_OFS = 3'o6;

    // CSR / RBUF bit positions (READY shares the DONE position in XCSR).
    localparam int DONE_BIT = 7;
    localparam int IE_BIT   = 6;
    localparam int OVR_BIT  = 15;
    localparam int FERR_BIT = 14;

    localparam int RX_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} ser_state_t;

endpackage

// File: rtl/serial_rx_core.sv
// serial_rx_core: 2-FF synchroniser, 8N1 receive FSM and framing-error flag.
// Emits a one-cycle o_byte_valid with the received byte and its FERR status.
module serial_rx_core
    import serial_pkg::*;
#(
    parameter int BAUD_DIV = 417
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_init,
    input  logic       i_rx,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_ferr
);
    localparam logic [11:0] FULL = 12'(BAUD_DIV - 1);
    localparam logic [11:0] HALF = 12'(BAUD_DIV / 2 - 1);

    ser_state_t  r_state, w_next;
    logic [1:0]  r_sync;
    logic        r_prev;
    logic [11:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_shift;
    logic        w_rx, w_tick;

    assign w_rx   = r_sync[1];
    assign w_tick = (r_cnt == 12'd0);
    assign o_byte = r_shift;

    // Synchronise the asynchronous line; INIT deliberately leaves these flops alone.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync <= 2'b11;
            r_prev <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_rx};
            r_prev <= w_rx;
        end
    end

    // RX state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)       r_state <= S_IDLE;
        else if (i_init) r_state <= S_IDLE;
        else             r_state <= w_next;
    end

    // Next state: a half-bit wait validates the start bit, then full-bit sampling.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_prev && !w_rx) w_next = S_START;
            S_START: if (w_tick) w_next = w_rx ? S_IDLE : S_DATA;
            S_DATA:  if (w_tick && r_bit == 3'd7) w_next = S_STOP;
            S_STOP:  if (w_tick) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Bit timer, LSB-first shift register and delivery pulse.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst || i_init) begin
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            o_byte_valid <= 1'b0;
            o_ferr       <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            if (r_state == S_IDLE) r_cnt <= HALF;
            else if (w_tick)       r_cnt <= FULL;
            else                   r_cnt <= r_cnt - 12'd1;
            if (r_state == S_START) r_bit <= '0;
            if (r_state == S_DATA && w_tick) begin
                r_shift <= {w_rx, r_shift[7:1]};
                r_bit   <= r_bit + 3'd1;
            end
            if (r_state == S_STOP && w_tick) begin
                o_byte_valid <= 1'b1;
                o_ferr       <= ~w_rx;
            end
        end
    end

endmodule

// File: rtl/bus_serial_port.sv
// bus_serial_port: DL11-style serial port on the vm1 bus (RCSR/RBUF/XCSR/XBUF),
// 8N1 transmitter, receiver (serial_rx_core) and RX/TX vectored interrupt requests.
// Optional build macro SERIAL_RX_FIFO_EN places a 4-entry RX FIFO behind RBUF;
// without it RBUF is a single holding register that is overwritten (OVR) on overrun.
module bus_serial_port
    import serial_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'o176560,
    parameter int          BAUD_DIV  = 417
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce,
    input  logic        init,
    input  logic        bus_sync,
    input  logic [15:0] bus_addr,
    input  logic        bus_stb,
    input  logic        bus_we,
    input  logic [1:0]  bus_wtbt,
    input  logic [15:0] bus_din,
    output logic [15:0] bus_dout,
    output logic        bus_ack,
    input  logic        rx_i,
    output logic        tx_o,
    output logic        virq_req_rx,
    input  logic        virq_ack_rx,
    output logic        virq_req_tx,
    input  logic        virq_ack_tx
);
    localparam logic [11:0] FULL = 12'(BAUD_DIV - 1);

    logic        w_sel, w_access, w_acc_rise, w_wr_lo, w_rbuf_rd, w_xbuf_wr;
    logic [2:0]  w_ofs;
    logic        r_access_d, r_rie, r_xie, r_ready, r_tx;
    logic [7:0]  r_txdata, r_tx_sh;
    logic [11:0] r_tx_cnt;
    logic [2:0]  r_tx_bit;
    ser_state_t  r_tx_state, w_tx_next;
    logic        w_tx_tick, w_tx_done;
    logic        w_rx_valid, w_rx_ferr;
    logic [7:0]  w_rx_byte;
    logic        w_done, w_ovr, w_ferr;
    logic [7:0]  w_rdata;
    logic        w_rx_cond, w_tx_cond, r_rx_cond_d, r_tx_cond_d;
    logic        w_unused;

    assign w_unused   = &{1'b0, bus_addr[0], bus_din[15:8], bus_wtbt[1]};
    assign w_sel      = bus_sync && (bus_addr[15:3] == BASE_ADDR[15:3]);
    assign w_ofs      = {bus_addr[2:1], 1'b0};
    assign w_access   = w_sel & bus_stb;
    assign w_acc_rise = w_access & ~r_access_d;
    assign w_wr_lo    = w_acc_rise & bus_we & bus_wtbt[0];
    assign w_rbuf_rd  = w_acc_rise & ~bus_we & (w_ofs == RBUF_OFS);
    assign w_xbuf_wr  = w_wr_lo & (w_ofs == XBUF_OFS) & r_ready;
    assign tx_o       = r_tx;

    serial_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .i_clk(clk_sys), .i_rst(reset), .i_init(init), .i_rx(rx_i),
        .o_byte_valid(w_rx_valid), .o_byte(w_rx_byte), .o_ferr(w_rx_ferr)
    );

    // Read mux; drives zero whenever this port is not being read (wired-OR bus).
    always_comb begin
        bus_dout = '0;
        if (w_access && !bus_we) begin
            case (w_ofs)
                RCSR_OFS: begin bus_dout[DONE_BIT] = w_done;  bus_dout[IE_BIT] = r_rie; end
                RBUF_OFS: bus_dout = {w_ovr, w_ferr, 6'b0, w_rdata};
                XCSR_OFS: begin bus_dout[DONE_BIT] = r_ready; bus_dout[IE_BIT] = r_xie; end
                default:  bus_dout = '0;
            endcase
        end
    end

    // Bus reply, strobe edge tracking and interrupt-enable bits.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset || init) begin
            bus_ack    <= 1'b0;
            r_access_d <= 1'b0;
            r_rie      <= 1'b0;
            r_xie      <= 1'b0;
        end else begin
            r_access_d <= w_access;
            if (ce) begin
                if (w_access)     bus_ack <= 1'b1;
                else if (!bus_stb) bus_ack <= 1'b0;
            end
            if (w_wr_lo && w_ofs == RCSR_OFS) r_rie <= bus_din[IE_BIT];
            if (w_wr_lo && w_ofs == XCSR_OFS) r_xie <= bus_din[IE_BIT];
        end
    end

`ifdef SERIAL_RX_FIFO_EN
    logic [8:0] r_fifo [RX_FIFO_DEPTH];
    logic [1:0] r_wp, r_rp;
    logic [2:0] r_cnt;
    logic       r_ovr, w_push, w_pop;

    assign w_push  = w_rx_valid && (r_cnt != 3'(RX_FIFO_DEPTH));
    assign w_pop   = w_rbuf_rd && (r_cnt != 3'd0);
    assign w_done  = (r_cnt != 3'd0);
    assign w_ovr   = r_ovr;
    assign w_ferr  = r_fifo[r_rp][8];
    assign w_rdata = r_fifo[r_rp][7:0];

    // RX FIFO: FERR rides with each byte; a byte arriving while full is dropped.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset || init) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) r_fifo[i] <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovr <= 1'b0;
        end else begin
            if (w_push) begin
                r_fifo[r_wp] <= {w_rx_ferr, w_rx_byte};
                r_wp         <= r_wp + 2'd1;
            end
            if (w_pop) r_rp <= r_rp + 2'd1;
            r_cnt <= r_cnt + 3'(w_push) - 3'(w_pop);
            if (w_rx_valid && !w_push) r_ovr <= 1'b1;
            else if (w_rbuf_rd)        r_ovr <= 1'b0;
        end
    end
`else
    logic       r_done, r_ovr, r_ferr;
    logic [7:0] r_rdata;

    assign w_done  = r_done;
    assign w_ovr   = r_ovr;
    assign w_ferr  = r_ferr;
    assign w_rdata = r_rdata;

    // Single holding register; a delivery beats a same-cycle RBUF read.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset || init) begin
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
            r_rdata <= '0;
        end else if (w_rx_valid) begin
            r_done  <= 1'b1;
            r_ovr   <= r_done & ~w_rbuf_rd;
            r_ferr  <= w_rx_ferr;
            r_rdata <= w_rx_byte;
        end else if (w_rbuf_rd) begin
            r_done <= 1'b0;
            r_ovr  <= 1'b0;
            r_ferr <= 1'b0;
        end
    end
`endif

    assign w_tx_tick = (r_tx_cnt == 12'd0);
    assign w_tx_done = (r_tx_state == S_STOP) && w_tx_tick;

    // TX state register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)     r_tx_state <= S_IDLE;
        else if (init) r_tx_state <= S_IDLE;
        else           r_tx_state <= w_tx_next;
    end

    // TX next state: a pending byte (READY=0) launches a frame from IDLE.
    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            S_IDLE:  if (!r_ready) w_tx_next = S_START;
            S_START: if (w_tx_tick) w_tx_next = S_DATA;
            S_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = S_STOP;
            S_STOP:  if (w_tx_tick) w_tx_next = S_IDLE;
            default: w_tx_next = S_IDLE;
        endcase
    end

    // TX datapath: XBUF holding register, READY flag, bit timer and line driver.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset || init) begin
            r_ready  <= 1'b1;
            r_txdata <= '0;
            r_tx_sh  <= '0;
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
            r_tx     <= 1'b1;
        end else begin
            if (w_xbuf_wr) begin
                r_txdata <= bus_din[7:0];
                r_ready  <= 1'b0;
            end else if (w_tx_done) begin
                r_ready <= 1'b1;
            end
            if (r_tx_state == S_IDLE) begin
                r_tx_cnt <= FULL;
                r_tx_bit <= '0;
                r_tx_sh  <= r_txdata;
                r_tx     <= r_ready ? 1'b1 : 1'b0;
            end else if (!w_tx_tick) begin
                r_tx_cnt <= r_tx_cnt - 12'd1;
            end else begin
                r_tx_cnt <= FULL;
                if (r_tx_state == S_DATA) r_tx_bit <= r_tx_bit + 3'd1;
                if (r_tx_state == S_STOP || (r_tx_state == S_DATA && r_tx_bit == 3'd7)) begin
                    r_tx <= 1'b1;
                end else begin
                    r_tx    <= r_tx_sh[0];
                    r_tx_sh <= {1'b0, r_tx_sh[7:1]};
                end
            end
        end
    end

    assign w_rx_cond = w_done & r_rie;
    assign w_tx_cond = r_ready & r_xie;

    // Interrupt requests: set on the condition's rising edge, cleared by ack or by the condition falling.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset || init) begin
            virq_req_rx <= 1'b0;
            virq_req_tx <= 1'b0;
            r_rx_cond_d <= 1'b0;
            r_tx_cond_d <= 1'b0;
        end else begin
            r_rx_cond_d <= w_rx_cond;
            r_tx_cond_d <= w_tx_cond;
            if (w_rx_cond && !r_rx_cond_d)      virq_req_rx <= 1'b1;
            else if (virq_ack_rx || !w_rx_cond) virq_req_rx <= 1'b0;
            if (w_tx_cond && !r_tx_cond_d)      virq_req_tx <= 1'b1;
            else if (virq_ack_tx || !w_tx_cond) virq_req_tx <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_serial_port.sv
// tb_bus_serial_port: table-driven register checks plus hand-written TX/RX,
// interrupt, reset and glitch sequences for bus_serial_port.
module tb_bus_serial_port;
    localparam int BAUD = 16;
    localparam logic [15:0] A_RCSR = 16'o176560;
    localparam logic [15:0] A_RBUF = 16'o176562;
    localparam logic [15:0] A_XCSR = 16'o176564;
    localparam logic [15:0] A_XBUF = 16'o176566;

    logic clk = 1'b0, rst = 1'b1, ce = 1'b0, init = 1'b0;
    logic bus_sync = 1'b0, bus_stb = 1'b0, bus_we = 1'b0;
    logic [15:0] bus_addr = '0, bus_din = '0;
    logic [1:0]  bus_wtbt = '0;
    logic [15:0] bus_dout;
    logic bus_ack, rx_i = 1'b1, tx_o;
    logic virq_req_rx, virq_req_tx, virq_ack_rx = 1'b0, virq_ack_tx = 1'b0;

    int n_checks = 0;
    int n_errs   = 0;
    logic [15:0] exp_q[$];
    logic        tx_q[$];

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wd;
        logic [1:0]  wtbt;
        logic        hit;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[15];

    bus_serial_port #(.BASE_ADDR(16'o176560), .BAUD_DIV(BAUD)) dut (
        .clk_sys(clk), .reset(rst), .ce(ce), .init(init),
        .bus_sync(bus_sync), .bus_addr(bus_addr), .bus_stb(bus_stb), .bus_we(bus_we),
        .bus_wtbt(bus_wtbt), .bus_din(bus_din), .bus_dout(bus_dout), .bus_ack(bus_ack),
        .rx_i(rx_i), .tx_o(tx_o),
        .virq_req_rx(virq_req_rx), .virq_ack_rx(virq_ack_rx),
        .virq_req_tx(virq_req_tx), .virq_ack_tx(virq_ack_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ce <= ~ce;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %06o expected %06o", name, act, exp);
        end
    endtask

    task automatic bus_xfer(input logic [15:0] addr, input logic we, input logic [15:0] wd,
                            input logic [1:0] wtbt, input logic hit, output logic [15:0] rd);
        int n;
        @(negedge clk);
        bus_sync = 1'b1; bus_addr = addr; bus_we = we; bus_din = wd; bus_wtbt = wtbt; bus_stb = 1'b1;
        #1 rd = bus_dout;
        n = 0;
        while (bus_ack !== 1'b1 && n < 8) begin @(negedge clk); n++; end
        check("ack", {15'd0, bus_ack}, {15'd0, hit});
        bus_stb = 1'b0; bus_sync = 1'b0; bus_we = 1'b0;
        n = 0;
        while (bus_ack !== 1'b0 && n < 8) begin @(negedge clk); n++; end
        check("ack_clr", {15'd0, bus_ack}, 16'd0);
    endtask

    task automatic rd(input string name, input logic [15:0] addr, input logic [15:0] exp);
        logic [15:0] v;
        exp_q.push_back(exp);
        bus_xfer(addr, 1'b0, 16'd0, 2'b00, 1'b1, v);
        check(name, v, exp_q.pop_front());
    endtask

    task automatic wr(input logic [15:0] addr, input logic [15:0] d, input logic [1:0] wtbt);
        logic [15:0] v;
        bus_xfer(addr, 1'b1, d, wtbt, 1'b1, v);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); rx_i = f[i];
            repeat (BAUD - 1) @(negedge clk);
        end
        @(negedge clk); rx_i = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic tx_capture();
        int n;
        n = 0;
        while (tx_o !== 1'b0 && n < 64) begin @(negedge clk); n++; end
        check("tx_start_seen", {15'd0, tx_o}, 16'd0);
        repeat (BAUD / 2) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("tx_bit%0d", i), {15'd0, tx_o}, {15'd0, tx_q.pop_front()});
            if (i < 9) repeat (BAUD) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] v;
        logic [9:0]  f;
        logic        stuck;
        tbl[0]  = '{A_RCSR,        1'b0, 16'o000000, 2'b00, 1'b1, 16'o000000};
        tbl[1]  = '{A_RBUF,        1'b0, 16'o000000, 2'b00, 1'b1, 16'o000000};
        tbl[2]  = '{A_XCSR,        1'b0, 16'o000000, 2'b00, 1'b1, 16'o000200};
        tbl[3]  = '{A_XBUF,        1'b0, 16'o000000, 2'b00, 1'b1, 16'o000000};
        tbl[4]  = '{A_RCSR,        1'b1, 16'o000100, 2'b01, 1'b1, 16'o000000};
        tbl[5]  = '{A_RCSR,        1'b0, 16'o000000, 2'b00, 1'b1, 16'o000100};
        tbl[6]  = '{A_RCSR,        1'b1, 16'o000000, 2'b10, 1'b1, 16'o000000};
        tbl[7]  = '{16'o176561,    1'b0, 16'o000000, 2'b00, 1'b1, 16'o000100};
        tbl[8]  = '{A_RCSR,        1'b1, 16'o177777, 2'b01, 1'b1, 16'o000000};
        tbl[9]  = '{A_RCSR,        1'b0, 16'o000000, 2'b00, 1'b1, 16'o000100};
        tbl[10] = '{A_RCSR,        1'b1, 16'o000000, 2'b01, 1'b1, 16'o000000};
        tbl[11] = '{A_RCSR,        1'b0, 16'o000000, 2'b00, 1'b1, 16'o000000};
        tbl[12] = '{16'o176570,    1'b0, 16'o000000, 2'b00, 1'b0, 16'o000000};
        tbl[13] = '{A_XCSR,        1'b1, 16'o000100, 2'b01, 1'b1, 16'o000000};
        tbl[14] = '{A_XCSR,        1'b0, 16'o000000, 2'b00, 1'b1, 16'o000300};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_dout", bus_dout, 16'd0);
        check("rst_ack", {15'd0, bus_ack}, 16'd0);
        check("rst_tx", {15'd0, tx_o}, 16'd1);
        check("rst_reqs", {14'd0, virq_req_rx, virq_req_tx}, 16'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Register table
        for (int i = 0; i < 15; i++) begin
            exp_q.push_back(tbl[i].exp);
            bus_xfer(tbl[i].addr, tbl[i].we, tbl[i].wd, tbl[i].wtbt, tbl[i].hit, v);
            check($sformatf("vec%0d", i), v, exp_q.pop_front());
        end
        #1 check("xie_req_tx", {15'd0, virq_req_tx}, 16'd1);
        wr(A_XCSR, 16'o000000, 2'b01);
        #1 check("xie_off_req_tx", {15'd0, virq_req_tx}, 16'd0);
        check("idle_dout", bus_dout, 16'd0);

        // TX frame of 0o101, with a read and an ignored write during the frame
        f = {1'b1, 8'o101, 1'b0};
        for (int i = 0; i < 10; i++) tx_q.push_back(f[i]);
        fork
            tx_capture();
            begin
                wr(A_XBUF, 16'o000101, 2'b01);
                rd("xcsr_busy", A_XCSR, 16'o000000);
                wr(A_XBUF, 16'o000377, 2'b01);
            end
        join
        repeat (BAUD) @(negedge clk);
        rd("xcsr_ready", A_XCSR, 16'o000200);
        stuck = 1'b1;
        for (int i = 0; i < 3 * BAUD; i++) begin @(negedge clk); stuck = stuck & tx_o; end
        check("tx_no_second_frame", {15'd0, stuck}, 16'd1);

        // RX of 0x5A
        send_frame(8'h5A, 1'b1);
        rd("rcsr_done", A_RCSR, 16'o000200);
        rd("rbuf_5a", A_RBUF, 16'o000132);
        rd("rcsr_cleared", A_RCSR, 16'o000000);

        // Two bytes without reading RBUF
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
`ifdef SERIAL_RX_FIFO_EN
        rd("fifo_b1", A_RBUF, 16'h0011);
        rd("fifo_b2", A_RBUF, 16'h0022);
`else
        rd("overrun", A_RBUF, 16'h8022);
`endif
        rd("rcsr_empty", A_RCSR, 16'o000000);

        // RX interrupt
        wr(A_RCSR, 16'o000100, 2'b01);
        #1 check("req_rx_idle", {15'd0, virq_req_rx}, 16'd0);
        send_frame(8'h33, 1'b1);
        check("req_rx_set", {15'd0, virq_req_rx}, 16'd1);
        @(negedge clk); virq_ack_rx = 1'b1;
        @(negedge clk); virq_ack_rx = 1'b0;
        check("req_rx_acked", {15'd0, virq_req_rx}, 16'd0);
        repeat (3 * BAUD) @(negedge clk);
        check("req_rx_no_reraise", {15'd0, virq_req_rx}, 16'd0);
        rd("rbuf_33", A_RBUF, 16'h0033);
        send_frame(8'h44, 1'b1);
        check("req_rx_next_byte", {15'd0, virq_req_rx}, 16'd1);
        rd("rbuf_44", A_RBUF, 16'h0044);
        repeat (2) @(negedge clk);
        check("req_rx_cond_drop", {15'd0, virq_req_rx}, 16'd0);
        wr(A_RCSR, 16'o000000, 2'b01);

        // INIT clears XIE and the TX request
        wr(A_XCSR, 16'o000100, 2'b01);
        #1 check("req_tx_pre_init", {15'd0, virq_req_tx}, 16'd1);
        @(negedge clk); init = 1'b1;
        @(negedge clk); init = 1'b0;
        check("req_tx_init", {15'd0, virq_req_tx}, 16'd0);
        rd("xcsr_init", A_XCSR, 16'o000200);

        // Reset in the middle of a TX frame
        wr(A_XCSR, 16'o000100, 2'b01);
        wr(A_XBUF, 16'h0000, 2'b01);
        repeat (5 * BAUD) @(negedge clk);
        check("tx_bit4_low", {15'd0, tx_o}, 16'd0);
        #2 rst = 1'b1;
        #1 check("tx_reset_now", {15'd0, tx_o}, 16'd1);
        check("req_tx_reset", {15'd0, virq_req_tx}, 16'd0);
        @(negedge clk); rst = 1'b0;
        rd("xcsr_after_reset", A_XCSR, 16'o000200);

        // Short low glitch must not start a byte, then a frame with a low stop bit
        @(negedge clk); rx_i = 1'b0;
        repeat (BAUD / 4) @(negedge clk);
        rx_i = 1'b1;
        repeat (2 * BAUD) @(negedge clk);
        rd("glitch_no_done", A_RCSR, 16'o000000);
        send_frame(8'h5A, 1'b0);
        rd("ferr", A_RBUF, 16'h405A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
